// File: rtl/audio_recorder_sram_if.sv
// Record-stream handshake between the audio bus controller (master) and the recorder (slave).
interface audio_recorder_sram_if;
  logic        record_audio_ready;
  logic [31:0] record_audio_data;
  logic        record_audio_valid;

  modport master (
    output record_audio_data,
    output record_audio_valid,
    input  record_audio_ready
  );

  modport slave (
    input  record_audio_data,
    input  record_audio_valid,
    output record_audio_ready
  );
endinterface

// File: rtl/audio_recorder_sram.sv
// Stereo record sink: each accepted 32-bit sample is written to 16-bit SRAM as left then right,
// with an auto-incrementing address that stops on a stop command or when memory is full.
module audio_recorder_sram #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned WR_CYCLES = 2,
  parameter int unsigned MAX_ADDR  = (2 ** ADDR_W) - 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_pause,
  audio_recorder_sram_if.slave  rec,
  output logic [ADDR_W-1:0]     o_sram_addr,
  output logic [15:0]           o_sram_wdata,
  output logic                  o_sram_we_n,
  output logic [ADDR_W-1:0]     o_end_addr,
  output logic                  o_full,
  output logic                  o_done,
  output logic [2:0]            o_state
);

  // One extra bit so the end address can reach MAX_ADDR+1 without wrapping.
  localparam int unsigned EndW = ADDR_W + 1;
  localparam int unsigned CntW = $clog2(WR_CYCLES + 1);

  localparam logic [CntW-1:0] CntGap     = CntW'(WR_CYCLES);
  localparam logic [CntW-1:0] CntLastLow = CntW'(WR_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [EndW-1:0] LastStart  = EndW'(MAX_ADDR - 1);
  localparam logic [EndW-1:0] EndOne     = EndW'(1);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWait = 3'd1,
    StWrL  = 3'd2,
    StWrR  = 3'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hold_q, hold_d;
  logic [EndW-1:0]   end_q, end_d;
  logic              full_q, full_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic              we_n;
  logic              ready;
  logic              accept;
  logic [EndW-1:0]   end_inc;

  assign ready   = (state_q == StWait) && !i_pause;
  assign accept  = ready && rec.record_audio_valid;
  assign end_inc = end_q + EndOne;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    end_d   = end_q;
    full_d  = full_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    we_n    = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (i_start && !i_stop) begin
          state_d = StWait;
          end_d   = '0;
          full_d  = 1'b0;
          pend_d  = 1'b0;
        end
      end
      StWait: begin
        if (accept) begin
          hold_d  = rec.record_audio_data;
          cnt_d   = '0;
          pend_d  = i_stop;
          state_d = StWrL;
        end else if (i_stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StWrL: begin
        if (i_stop) pend_d = 1'b1;
        // Final count is the we_n-high gap that separates left from right.
        if (cnt_q == CntGap) begin
          cnt_d   = '0;
          end_d   = end_inc;
          state_d = StWrR;
        end else begin
          we_n  = 1'b0;
          cnt_d = cnt_q + CntOne;
        end
      end
      StWrR: begin
        we_n = 1'b0;
        if (i_stop) pend_d = 1'b1;
        if (cnt_q == CntLastLow) begin
          cnt_d = '0;
          end_d = end_inc;
          if (pend_q || i_stop || (end_inc > LastStart)) begin
            state_d = StIdle;
            done_d  = 1'b1;
            pend_d  = 1'b0;
            if (end_inc > LastStart) full_d = 1'b1;
          end else begin
            state_d = StWait;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hold_q  <= '0;
      end_q   <= '0;
      full_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      end_q   <= end_d;
      full_q  <= full_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  assign rec.record_audio_ready = ready;
  assign o_sram_addr  = end_q[ADDR_W-1:0];
  assign o_sram_wdata = (state_q == StWrR) ? hold_q[15:0] : hold_q[31:16];
  assign o_sram_we_n  = we_n;
  assign o_end_addr   = end_q[ADDR_W-1:0];
  assign o_full       = full_q;
  assign o_done       = done_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_audio_recorder_sram.sv
// Bench for audio_recorder_sram: a default-size instance plus a MAX_ADDR=5 instance for the
// full-memory case; expected SRAM writes are queued on accept and popped as words appear.
module tb_audio_recorder_sram;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic b_start = 1'b0, b_stop = 1'b0, b_pause = 1'b0;

  logic [19:0] a_addr, a_end;
  logic [15:0] a_wdata;
  logic        a_we_n, a_full, a_done;
  logic [2:0]  a_state;
  logic [3:0]  b_addr, b_end;
  logic [15:0] b_wdata;
  logic        b_we_n, b_full, b_done;
  logic [2:0]  b_state;

  audio_recorder_sram_if if_a ();
  audio_recorder_sram_if if_b ();

  audio_recorder_sram u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_pause(pause),
    .rec(if_a.slave), .o_sram_addr(a_addr), .o_sram_wdata(a_wdata), .o_sram_we_n(a_we_n),
    .o_end_addr(a_end), .o_full(a_full), .o_done(a_done), .o_state(a_state)
  );

  audio_recorder_sram #(.ADDR_W(4), .WR_CYCLES(2), .MAX_ADDR(5)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_stop(b_stop), .i_pause(b_pause),
    .rec(if_b.slave), .o_sram_addr(b_addr), .o_sram_wdata(b_wdata), .o_sram_we_n(b_we_n),
    .o_end_addr(b_end), .o_full(b_full), .o_done(b_done), .o_state(b_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int mdl_a = 0;
  int mdl_b = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  logic [35:0] exp_a[$];
  logic [19:0] exp_b[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write monitor for instance A: pop on first low cycle, then check stability and length.
  initial begin : mon_a
    logic prev;
    int low;
    logic [35:0] first, e;
    prev = 1'b1;
    low = 0;
    first = '0;
    forever begin
      @(negedge clk);
      if (a_done === 1'b1) a_done_cnt++;
      if (a_we_n === 1'b0) begin
        if (prev) begin
          low = 1;
          first = {a_addr, a_wdata};
          n_checks++;
          if (exp_a.size() == 0) begin
            n_fail++;
            $display("FAIL a_write: got addr=%h data=%h, required no write", a_addr, a_wdata);
          end else begin
            e = exp_a.pop_front();
            if ({a_addr, a_wdata} !== e) begin
              n_fail++;
              $display("FAIL a_write: got addr=%h data=%h, required addr=%h data=%h",
                       a_addr, a_wdata, e[35:16], e[15:0]);
            end
          end
        end else begin
          low++;
          n_checks++;
          if ({a_addr, a_wdata} !== first) begin
            n_fail++;
            $display("FAIL a_stable: got %h, required %h", {a_addr, a_wdata}, first);
          end
        end
      end else if (!prev && rst_n) begin
        n_checks++;
        if (low != 2) begin
          n_fail++;
          $display("FAIL a_we_len: got %0d low cycles, required 2", low);
        end
      end
      prev = (a_we_n !== 1'b0);
    end
  end

  initial begin : mon_b
    logic prev;
    int low;
    logic [19:0] first, e;
    prev = 1'b1;
    low = 0;
    first = '0;
    forever begin
      @(negedge clk);
      if (b_done === 1'b1) b_done_cnt++;
      if (b_we_n === 1'b0) begin
        if (prev) begin
          low = 1;
          first = {b_addr, b_wdata};
          n_checks++;
          if (exp_b.size() == 0) begin
            n_fail++;
            $display("FAIL b_write: got addr=%h data=%h, required no write", b_addr, b_wdata);
          end else begin
            e = exp_b.pop_front();
            if ({b_addr, b_wdata} !== e) begin
              n_fail++;
              $display("FAIL b_write: got addr=%h data=%h, required addr=%h data=%h",
                       b_addr, b_wdata, e[19:16], e[15:0]);
            end
          end
        end else begin
          low++;
          n_checks++;
          if ({b_addr, b_wdata} !== first) begin
            n_fail++;
            $display("FAIL b_stable: got %h, required %h", {b_addr, b_wdata}, first);
          end
        end
      end else if (!prev && rst_n) begin
        n_checks++;
        if (low != 2) begin
          n_fail++;
          $display("FAIL b_we_len: got %0d low cycles, required 2", low);
        end
      end
      prev = (b_we_n !== 1'b0);
    end
  end

  task automatic pulse_a(input bit do_start, input bit do_stop);
    @(posedge clk); #1;
    start = do_start;
    stop = do_stop;
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic send_a(input logic [31:0] d, output int t);
    bit ok;
    ok = 1'b0;
    t = 0;
    @(posedge clk); #1;
    if_a.record_audio_valid = 1'b1;
    if_a.record_audio_data = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (if_a.record_audio_ready === 1'b1) ok = 1'b1;
    end
    t = cyc;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL a_accept: sample %h not accepted, required accept within 50 cycles", d);
    end else begin
      exp_a.push_back({20'(mdl_a), d[31:16]});
      exp_a.push_back({20'(mdl_a + 1), d[15:0]});
      mdl_a += 2;
    end
    @(posedge clk); #1;
    if_a.record_audio_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    if_b.record_audio_valid = 1'b1;
    if_b.record_audio_data = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (if_b.record_audio_ready === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b_accept: sample %h not accepted, required accept within 50 cycles", d);
    end else begin
      exp_b.push_back({4'(mdl_b), d[31:16]});
      exp_b.push_back({4'(mdl_b + 1), d[15:0]});
      mdl_b += 2;
    end
    @(posedge clk); #1;
    if_b.record_audio_valid = 1'b0;
  endtask

  task automatic wait_ready_a(output int t, output bit ok);
    ok = 1'b0;
    t = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (if_a.record_audio_ready === 1'b1) begin
        ok = 1'b1;
        t = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({a_state, a_we_n, if_a.record_audio_ready, a_end, a_full, a_done, a_addr, a_wdata}
        !== {3'd0, 1'b1, 1'b0, 20'd0, 1'b0, 1'b0, 20'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_a: state=%0d we_n=%b rdy=%b end=%h full=%b done=%b addr=%h wd=%h, %s",
               a_state, a_we_n, if_a.record_audio_ready, a_end, a_full, a_done, a_addr,
               a_wdata, "required all 0 except we_n=1");
    end
    n_checks++;
    if ({b_state, b_we_n, if_b.record_audio_ready, b_end, b_full, b_done}
        !== {3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_b: state=%0d we_n=%b end=%h full=%b, required 0/1/0/0",
               b_state, b_we_n, b_end, b_full);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int t, t2;
    bit ok;
    pulse_a(1'b1, 1'b0);
    mdl_a = 0;
    @(negedge clk);
    n_checks++;
    if (a_state !== 3'd1 || if_a.record_audio_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_wait: state=%0d ready=%b, required 1/1", a_state,
               if_a.record_audio_ready);
    end
    send_a(32'h1234_ABCD, t);
    wait_ready_a(t2, ok);
    n_checks++;
    if (!ok || t2 != t + 6) begin
      n_fail++;
      $display("FAIL ready_latency: got %0d cycles (ok=%b), required 6", t2 - t, ok);
    end
    n_checks++;
    if (a_end !== 20'd2 || exp_a.size() != 0) begin
      n_fail++;
      $display("FAIL single_end: end=%0d pending=%0d, required end=2 pending=0", a_end,
               exp_a.size());
    end
  endtask

  task automatic test_back_to_back();
    int t, d0;
    bit ok;
    logic [31:0] pat[3];
    pat[0] = 32'hDEAD_BEEF;
    pat[1] = 32'h0001_FFFE;
    pat[2] = 32'h8000_7FFF;
    d0 = a_done_cnt;
    pulse_a(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_state !== 3'd0 || a_done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL stop_wait: state=%0d done_pulses=%0d, required 0/1", a_state,
               a_done_cnt - d0);
    end
    pulse_a(1'b1, 1'b0);
    mdl_a = 0;
    for (int i = 0; i < 3; i++) send_a(pat[i], t);
    wait_ready_a(t, ok);
    d0 = a_done_cnt;
    pulse_a(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (!ok || a_end !== 20'd6 || a_done_cnt != d0 + 1 || a_state !== 3'd0 ||
        if_a.record_audio_ready !== 1'b0 || exp_a.size() != 0) begin
      n_fail++;
      $display("FAIL b2b: end=%0d done_pulses=%0d state=%0d rdy=%b pend=%0d, %s", a_end,
               a_done_cnt - d0, a_state, if_a.record_audio_ready, exp_a.size(),
               "required 6/1/0/0/0");
    end
  endtask

  task automatic test_stop_during_write();
    int t, d0;
    bit ok;
    pulse_a(1'b1, 1'b0);
    mdl_a = 0;
    d0 = a_done_cnt;
    send_a(32'hCAFE_F00D, t);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (a_done === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok || a_end !== 20'd2 || a_state !== 3'd0 || exp_a.size() != 0) begin
      n_fail++;
      $display("FAIL stop_in_wrl: done=%b end=%0d state=%0d pend=%0d, required 1/2/0/0", ok,
               a_end, a_state, exp_a.size());
    end
    d0 = a_done_cnt;
    pulse_a(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_done_cnt != d0 || a_state !== 3'd0 || a_end !== 20'd2) begin
      n_fail++;
      $display("FAIL stop_in_idle: done_pulses=%0d state=%0d end=%0d, required 0/0/2",
               a_done_cnt - d0, a_state, a_end);
    end
  endtask

  task automatic test_pause();
    int t;
    bit ok, bad;
    pulse_a(1'b1, 1'b0);
    mdl_a = 0;
    @(posedge clk); #1;
    pause = 1'b1;
    if_a.record_audio_valid = 1'b1;
    if_a.record_audio_data = 32'h5A5A_0F0F;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (if_a.record_audio_ready !== 1'b0 || a_we_n !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL pause_hold: ready or write seen while paused, required none");
    end
    @(posedge clk); #1;
    pause = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_a.record_audio_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_release: ready=%b, required 1", if_a.record_audio_ready);
    end
    exp_a.push_back({20'd0, 16'h5A5A});
    exp_a.push_back({20'd1, 16'h0F0F});
    mdl_a = 2;
    @(posedge clk); #1;
    if_a.record_audio_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_state !== 3'd2) begin
      n_fail++;
      $display("FAIL pause_accept: state=%0d, required 2", a_state);
    end
    wait_ready_a(t, ok);
    n_checks++;
    if (!ok || a_end !== 20'd2 || exp_a.size() != 0) begin
      n_fail++;
      $display("FAIL pause_end: ok=%b end=%0d pend=%0d, required 1/2/0", ok, a_end,
               exp_a.size());
    end
  endtask

  task automatic test_reset_mid_write();
    int t, d0;
    bit ok, bad;
    send_a(32'h7777_8888, t);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (a_state === 3'd3) ok = 1'b1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!ok || a_we_n !== 1'b1 || a_state !== 3'd0 || a_end !== 20'd0) begin
      n_fail++;
      $display("FAIL rst_mid_wrr: reached=%b we_n=%b state=%0d end=%0d, required 1/1/0/0",
               ok, a_we_n, a_state, a_end);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    d0 = a_done_cnt;
    pulse_a(1'b1, 1'b1);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_state !== 3'd0 || if_a.record_audio_ready !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad || a_done_cnt != d0 || exp_a.size() != 0) begin
      n_fail++;
      $display("FAIL start_stop_idle: left IDLE=%b done_pulses=%0d pend=%0d, required 0/0/0",
               bad, a_done_cnt - d0, exp_a.size());
    end
  endtask

  task automatic test_full();
    bit ok, bad;
    logic [31:0] pat[3];
    pat[0] = 32'h1111_2222;
    pat[1] = 32'h3333_4444;
    pat[2] = 32'h5555_6666;
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    mdl_b = 0;
    for (int i = 0; i < 3; i++) send_b(pat[i]);
    if_b.record_audio_valid = 1'b1;
    if_b.record_audio_data = 32'h7777_8888;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (b_done === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok || b_full !== 1'b1 || b_end !== 4'd6 || b_state !== 3'd0) begin
      n_fail++;
      $display("FAIL full_stop: done=%b full=%b end=%0d state=%0d, required 1/1/6/0", ok,
               b_full, b_end, b_state);
    end
    bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (if_b.record_audio_ready !== 1'b0 || b_we_n !== 1'b1) bad = 1'b1;
    end
    if_b.record_audio_valid = 1'b0;
    n_checks++;
    if (bad || b_done_cnt != 1 || exp_b.size() != 0 || b_end !== 4'd6) begin
      n_fail++;
      $display("FAIL full_hold: extra_activity=%b done_pulses=%0d pend=%0d end=%0d, %s", bad,
               b_done_cnt, exp_b.size(), b_end, "required 0/1/0/6");
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.record_audio_valid = 1'b0;
    if_a.record_audio_data = '0;
    if_b.record_audio_valid = 1'b0;
    if_b.record_audio_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stop_during_write();
    test_pause();
    test_reset_mid_write();
    test_full();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: a=%0d b=%0d words outstanding, required 0",
               exp_a.size(), exp_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
